// File: rtl/tnn_pkg.sv
// Shared types and width/index helpers for the time-multiplexed ternary classifier.
package tnn_pkg;

  typedef enum logic [2:0] {StIdle, StL1, StL2, StArgmax, StOut} state_e;

  function automatic int unsigned acc1_bits(input int unsigned feat_bits,
                                            input int unsigned feat_cnt);
    return feat_bits + $clog2(feat_cnt + 1) + 1;
  endfunction

  function automatic int unsigned acc2_bits(input int unsigned hidden_cnt);
    return $clog2(hidden_cnt + 1) + 1;
  endfunction

  function automatic int unsigned idx_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned w1_idx(input int unsigned f, input int unsigned h,
                                         input int unsigned feat_cnt);
    return h * feat_cnt + f;
  endfunction

  function automatic int unsigned w2_idx(input int unsigned h, input int unsigned c,
                                         input int unsigned hidden_cnt);
    return c * hidden_cnt + h;
  endfunction

endpackage

// File: rtl/tnn_argmax.sv
// Combinational argmax over packed signed scores; ties resolve to the lowest index.
module tnn_argmax
  import tnn_pkg::*;
#(
  parameter int unsigned CLASS_CNT  = 3,
  parameter int unsigned SCORE_BITS = 7
) (
  input  logic [CLASS_CNT*SCORE_BITS-1:0]  scores,
  output logic [idx_bits(CLASS_CNT)-1:0]   index
);

  localparam int unsigned IW = idx_bits(CLASS_CNT);

  logic signed [SCORE_BITS-1:0] best;
  logic signed [SCORE_BITS-1:0] cur;

  always_comb begin
    best  = signed'(scores[SCORE_BITS-1:0]);
    cur   = best;
    index = '0;
    // Strict compare keeps the earlier index on a tie.
    for (int unsigned c = 1; c < CLASS_CNT; c++) begin
      cur = signed'(scores[c*SCORE_BITS +: SCORE_BITS]);
      if (cur > best) begin
        best  = cur;
        index = IW'(c);
      end
    end
  end

endmodule

// File: rtl/tnn_seq_classifier.sv
// Sequential ternary NN classifier: one feature per cycle into all hidden neurons,
// then one hidden bit per cycle into all class scores, then a registered argmax.
module tnn_seq_classifier
  import tnn_pkg::*;
#(
  parameter int unsigned FEAT_CNT   = 19,
  parameter int unsigned FEAT_BITS  = 4,
  parameter int unsigned HIDDEN_CNT = 40,
  parameter int unsigned CLASS_CNT  = 3,
  parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]  W1_POS = '0,
  parameter logic [FEAT_CNT*HIDDEN_CNT-1:0]  W1_NEG = '0,
  parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] W2_POS = '0,
  parameter logic [HIDDEN_CNT*CLASS_CNT-1:0] W2_NEG = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [FEAT_BITS*FEAT_CNT-1:0]     data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [idx_bits(CLASS_CNT)-1:0]    prediction
);

  localparam int unsigned A1W = acc1_bits(FEAT_BITS, FEAT_CNT);
  localparam int unsigned A2W = acc2_bits(HIDDEN_CNT);
  localparam int unsigned FW  = idx_bits(FEAT_CNT);
  localparam int unsigned HW  = idx_bits(HIDDEN_CNT);
  localparam int unsigned PW  = idx_bits(CLASS_CNT);
  localparam logic signed [A2W-1:0] Unit = 1;

  state_e state_q, state_d;

  logic [FEAT_BITS*FEAT_CNT-1:0] data_q;
  logic [FW-1:0]                 f_q;
  logic [HW-1:0]                 h_q;
  logic [PW-1:0]                 pred_q;
  logic signed [A1W-1:0]         acc1_q [HIDDEN_CNT];
  logic signed [A2W-1:0]         acc2_q [CLASS_CNT];

  logic [FEAT_BITS-1:0]          feat_cur;
  logic signed [A1W-1:0]         feat_ext;
  logic                          hid_bit;
  logic [CLASS_CNT*A2W-1:0]      scores;
  logic [PW-1:0]                 best_idx;

  assign feat_cur = data_q[32'(f_q)*FEAT_BITS +: FEAT_BITS];
  assign feat_ext = signed'(A1W'(feat_cur));
  assign hid_bit  = ~acc1_q[h_q][A1W-1];

  always_comb begin
    scores = '0;
    for (int unsigned c = 0; c < CLASS_CNT; c++) begin
      scores[c*A2W +: A2W] = acc2_q[c];
    end
  end

  tnn_argmax #(
    .CLASS_CNT  (CLASS_CNT),
    .SCORE_BITS (A2W)
  ) u_argmax (
    .scores (scores),
    .index  (best_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StL1;
      end
      StL1:     if (f_q == FW'(FEAT_CNT - 1)) state_d = StL2;
      StL2:     if (h_q == HW'(HIDDEN_CNT - 1)) state_d = StArgmax;
      StArgmax: state_d = StOut;
      StOut: begin
        out_valid = 1'b1;
        if (out_ready) state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  assign prediction = pred_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      f_q    <= '0;
      h_q    <= '0;
      pred_q <= '0;
      for (int unsigned h = 0; h < HIDDEN_CNT; h++) acc1_q[h] <= '0;
      for (int unsigned c = 0; c < CLASS_CNT; c++) acc2_q[c] <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            data_q <= data;
            f_q    <= '0;
            for (int unsigned h = 0; h < HIDDEN_CNT; h++) acc1_q[h] <= '0;
            for (int unsigned c = 0; c < CLASS_CNT; c++) acc2_q[c] <= '0;
          end
        end
        StL1: begin
          // A weight with both polarity bits set is zero and leaves the sum alone.
          for (int unsigned h = 0; h < HIDDEN_CNT; h++) begin
            if (W1_POS[w1_idx(32'(f_q), h, FEAT_CNT)] && !W1_NEG[w1_idx(32'(f_q), h, FEAT_CNT)])
              acc1_q[h] <= acc1_q[h] + feat_ext;
            else if (W1_NEG[w1_idx(32'(f_q), h, FEAT_CNT)] &&
                     !W1_POS[w1_idx(32'(f_q), h, FEAT_CNT)])
              acc1_q[h] <= acc1_q[h] - feat_ext;
          end
          f_q <= f_q + FW'(1);
          if (f_q == FW'(FEAT_CNT - 1)) h_q <= '0;
        end
        StL2: begin
          for (int unsigned c = 0; c < CLASS_CNT; c++) begin
            if (W2_POS[w2_idx(32'(h_q), c, HIDDEN_CNT)] && !W2_NEG[w2_idx(32'(h_q), c, HIDDEN_CNT)])
              acc2_q[c] <= hid_bit ? acc2_q[c] + Unit : acc2_q[c] - Unit;
            else if (W2_NEG[w2_idx(32'(h_q), c, HIDDEN_CNT)] &&
                     !W2_POS[w2_idx(32'(h_q), c, HIDDEN_CNT)])
              acc2_q[c] <= hid_bit ? acc2_q[c] - Unit : acc2_q[c] + Unit;
          end
          h_q <= h_q + HW'(1);
        end
        StArgmax: pred_q <= best_idx;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tnn_seq_classifier.sv
// Bench: four classifier instances with different weight sets share one stimulus stream.
module tb_tnn_seq_classifier;

  localparam int FC = 19;
  localparam int FB = 4;
  localparam int HC = 40;
  localparam int CC = 3;
  localparam int DW = FC * FB;
  localparam int LAT = FC + HC + 1;

  function automatic logic [FC*HC-1:0] pat(input int unsigned seed);
    logic [FC*HC-1:0] r;
    int unsigned x;
    x = seed * 32'h9E3779B9 + 32'd1;
    for (int i = 0; i < FC * HC; i++) begin
      x = x ^ (x << 13);
      x = x ^ (x >> 17);
      x = x ^ (x << 5);
      r[i] = x[7];
    end
    return r;
  endfunction

  localparam logic [FC*HC-1:0] ZW1  = '0;
  localparam logic [HC*CC-1:0] ZW2  = '0;
  localparam logic [HC*CC-1:0] C2W2P = {{HC{1'b1}}, {(2*HC){1'b0}}};
  localparam logic [FC*HC-1:0] OW1N = (FC*HC)'(1);
  localparam logic [HC*CC-1:0] OW2P = (HC*CC)'(1) << HC;
  localparam logic [FC*HC-1:0] RW1P = pat(1);
  localparam logic [FC*HC-1:0] RW1N = pat(2);
  localparam logic [HC*CC-1:0] RW2P = (HC*CC)'(pat(3));
  localparam logic [HC*CC-1:0] RW2N = (HC*CC)'(pat(4));

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] data;
  logic [3:0]    ir;
  logic [3:0]    ov;
  logic [1:0]    pr [4];

  int nchk = 0;
  int nerr = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  tnn_seq_classifier u_zero (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .data(data),
    .out_valid(ov[0]), .out_ready(out_ready), .prediction(pr[0])
  );

  tnn_seq_classifier #(.W2_POS(C2W2P)) u_c2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .data(data),
    .out_valid(ov[1]), .out_ready(out_ready), .prediction(pr[1])
  );

  tnn_seq_classifier #(.W1_NEG(OW1N), .W2_POS(OW2P)) u_one (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .data(data),
    .out_valid(ov[2]), .out_ready(out_ready), .prediction(pr[2])
  );

  tnn_seq_classifier #(.W1_POS(RW1P), .W1_NEG(RW1N), .W2_POS(RW2P), .W2_NEG(RW2N)) u_rnd (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .data(data),
    .out_valid(ov[3]), .out_ready(out_ready), .prediction(pr[3])
  );

  function automatic int wt(input logic p, input logic n);
    if (p && !n) return 1;
    if (n && !p) return -1;
    return 0;
  endfunction

  // Reference: plain integer dot products, sign, second layer, first-max argmax.
  function automatic int model(input logic [DW-1:0] d, input logic [FC*HC-1:0] w1p,
                               input logic [FC*HC-1:0] w1n, input logic [HC*CC-1:0] w2p,
                               input logic [HC*CC-1:0] w2n);
    int sc [CC];
    int s;
    int best;
    for (int c = 0; c < CC; c++) sc[c] = 0;
    for (int h = 0; h < HC; h++) begin
      s = 0;
      for (int f = 0; f < FC; f++) s += wt(w1p[h*FC+f], w1n[h*FC+f]) * int'(d[f*FB +: FB]);
      for (int c = 0; c < CC; c++)
        sc[c] += wt(w2p[c*HC+h], w2n[c*HC+h]) * ((s >= 0) ? 1 : -1);
    end
    best = 0;
    for (int c = 1; c < CC; c++) if (sc[c] > sc[best]) best = c;
    return best;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n;
    in_valid = 1'b1;
    data = d;
    n = 0;
    while (!ir[3] && n < 200) begin
      tick;
      n++;
    end
    check("accept_ready", 32'(ir[3]), 1);
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      tick;
      lat++;
    end while (!ov[3] && lat < 200);
  endtask

  task automatic check_preds(input string tag, input logic [DW-1:0] d,
                             input int e0, input int e1, input int e2);
    check({tag, "_valid_all"}, 32'(ov), 32'hF);
    check({tag, "_zero"}, 32'(pr[0]), e0);
    check({tag, "_c2"}, 32'(pr[1]), e1);
    check({tag, "_one"}, 32'(pr[2]), e2);
    check({tag, "_rnd"}, 32'(pr[3]), model(d, RW1P, RW1N, RW2P, RW2N));
  endtask

  task automatic run(input string tag, input logic [DW-1:0] d, input int e2);
    int lat;
    send(d);
    wait_out(lat);
    check({tag, "_latency"}, lat, LAT);
    check_preds(tag, d, 0, 2, e2);
    tick;
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  typedef struct {
    logic [DW-1:0] d;
    int            exp_one;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t          tbl [5];
    logic [DW-1:0] d;
    logic [DW-1:0] bv [3];
    int            lat;
    logic [1:0]    held;
    int            acc_t [3];
    int            n_acc;
    int            n_out;
    logic          acc_now;

    tbl[0] = '{{{18{4'h5}}, 4'hF}, 0};
    tbl[1] = '{{{18{4'h5}}, 4'h0}, 1};
    tbl[2] = '{{DW{1'b0}}, 1};
    tbl[3] = '{{DW{1'b1}}, 0};
    tbl[4] = '{{{18{4'h0}}, 4'h1}, 0};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    data = '0;
    tick;
    tick;
    rst = 1'b0;
    check("rst_in_ready", 32'(ir), 32'hF);
    check("rst_out_valid", 32'(ov), 0);
    check("rst_pred_c2", 32'(pr[1]), 0);
    check("rst_pred_rnd", 32'(pr[3]), 0);

    for (int i = 0; i < 5; i++) run($sformatf("tbl%0d", i), tbl[i].d, tbl[i].exp_one);

    for (int i = 0; i < 8; i++) begin
      d = rand_vec();
      run($sformatf("rand%0d", i), d, model(d, ZW1, OW1N, OW2P, ZW2));
    end

    // Backpressure: output held for five cycles while in_valid is asserted.
    out_ready = 1'b0;
    d = rand_vec();
    send(d);
    wait_out(lat);
    check("bp_latency", lat, LAT);
    check_preds("bp", d, 0, 2, model(d, ZW1, OW1N, OW2P, ZW2));
    held = pr[3];
    in_valid = 1'b1;
    data = ~d;
    for (int i = 0; i < 5; i++) begin
      tick;
      check($sformatf("bp_hold_valid%0d", i), 32'(ov[3]), 1);
      check($sformatf("bp_hold_ready%0d", i), 32'(ir[3]), 0);
      check($sformatf("bp_hold_pred%0d", i), 32'(pr[3]), 32'(held));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick;
    check("bp_release_ready", 32'(ir[3]), 1);
    check("bp_release_valid", 32'(ov[3]), 0);
    tick;
    tick;
    check("bp_idle_ready", 32'(ir[3]), 1);

    // Reset in the middle of L1 discards the vector.
    send(rand_vec());
    repeat (9) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_in_ready", 32'(ir), 32'hF);
    check("midrst_out_valid", 32'(ov), 0);
    check("midrst_pred_c2", 32'(pr[1]), 0);
    d = rand_vec();
    run("post_rst", d, model(d, ZW1, OW1N, OW2P, ZW2));

    // Back-to-back with in_valid held high and out_ready tied.
    for (int i = 0; i < 3; i++) bv[i] = rand_vec();
    bv[1][3:0] = 4'h0;
    in_valid = 1'b1;
    data = bv[0];
    n_acc = 0;
    n_out = 0;
    for (int t = 0; t < 400 && n_out < 3; t++) begin
      acc_now = in_valid && ir[3];
      if (ov[3] && n_out < n_acc) begin
        check($sformatf("b2b_rnd%0d", n_out), 32'(pr[3]), model(bv[n_out], RW1P, RW1N, RW2P, RW2N));
        check($sformatf("b2b_one%0d", n_out), 32'(pr[2]), model(bv[n_out], ZW1, OW1N, OW2P, ZW2));
        n_out++;
      end
      tick;
      if (acc_now && n_acc < 3) begin
        acc_t[n_acc] = t;
        n_acc++;
        if (n_acc < 3) data = bv[n_acc];
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    check("b2b_outputs", n_out, 3);
    check("b2b_accepts", n_acc, 3);
    if (n_acc == 3) begin
      check("b2b_gap01", acc_t[1] - acc_t[0], LAT + 2);
      check("b2b_gap12", acc_t[2] - acc_t[1], LAT + 2);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/tnn_seq_classifier.md
Name: tnn_seq_classifier

Overview:
- Time-multiplexed ternary neural network classifier: one input layer (ternary weights on unsigned features), a binarised hidden layer, and one output layer followed by argmax.
- It replaces the fully combinational per-dataset classifiers with a single parametrised core. Weights come in as parameters, and a valid/ready handshake sits on both sides.
- It sits between the feature-vector source (test bench or input FIFO) and the prediction consumer.
- Latency is fixed and data-independent.

Parameters:
- FEAT_CNT, 19: number of input features.
- FEAT_BITS, 4: bits per unsigned feature.
- HIDDEN_CNT, 40: number of hidden neurons.
- CLASS_CNT, 3: number of output classes (2 or more).
- W1_POS, all zeros, width FEAT_CNT*HIDDEN_CNT: bit h*FEAT_CNT+f set means weight(f,h) = +1.
- W1_NEG, all zeros, width FEAT_CNT*HIDDEN_CNT: bit h*FEAT_CNT+f set means weight(f,h) = -1. If the same bit is set in both W1_POS and W1_NEG, the weight is 0.
- W2_POS, all zeros, width HIDDEN_CNT*CLASS_CNT: bit c*HIDDEN_CNT+h set means weight(h,c) = +1.
- W2_NEG, all zeros, width HIDDEN_CNT*CLASS_CNT: bit c*HIDDEN_CNT+h set means weight(h,c) = -1. Same both-set rule gives weight 0.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous active-high reset.
- in_valid, input, 1: data is valid.
- in_ready, output, 1: core can accept a vector.
- data, input, FEAT_BITS*FEAT_CNT: feature f is data[f*FEAT_BITS +: FEAT_BITS].
- out_valid, output, 1: prediction is valid.
- out_ready, input, 1: consumer accepts the prediction.
- prediction, output, $clog2(CLASS_CNT): winning class index.

Behaviour:
- Reset:
  - One clock, synchronous active-high reset on rst; all state updates on the rising edge of clk.
  - On rst, state goes to IDLE and all counters and accumulators clear.
  - Outputs after reset: in_ready=1, out_valid=0, prediction=0.
  - rst takes priority over every other event, including mid-L1 or mid-L2; any in-flight vector is discarded.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch data into an internal register, clear all accumulators, set f=0, go to L1.
- L1 (FEAT_CNT cycles):
  - For every h in parallel: acc1[h] += weight(f,h) * feat[f].
  - f increments each cycle. When f==FEAT_CNT-1, set h=0 and go to L2.
- L2 (HIDDEN_CNT cycles):
  - Hidden bit: b = (acc1[h] >= 0). b=1 maps to +1, b=0 maps to -1.
  - For every c in parallel: acc2[c] += weight(h,c) * (b ? +1 : -1).
  - When h==HIDDEN_CNT-1, go to ARGMAX.
- ARGMAX (1 cycle):
  - Register the index of the maximum acc2.
  - Ties go to the lowest index.
  - Go to OUT.
- OUT:
  - out_valid=1; prediction is held stable.
  - On out_ready, go to IDLE.
  - in_ready=0 here, so a new input is accepted no earlier than the cycle after the output handshake.
- Busy handling:
  - in_ready=0 in L1, L2, ARGMAX and OUT.
  - in_valid during those states is ignored and has no side effects.
  - out_valid=0 outside OUT.
- Latency: out_valid rises FEAT_CNT+HIDDEN_CNT+1 cycles after the accept edge (60 for the defaults).
- Widths:
  - acc1 is signed, FEAT_BITS+$clog2(FEAT_CNT+1)+1 bits.
  - acc2 is signed, $clog2(HIDDEN_CNT+1)+1 bits.
  - These widths cannot overflow. The feature is zero-extended before signed add/subtract.
- prediction holds its last value in every state except ARGMAX, where it is updated.

Decomposition:
- Shared package tnn_pkg:
  - State encoding IDLE/L1/L2/ARGMAX/OUT.
  - Width functions: acc1_bits(FEAT_BITS, FEAT_CNT), acc2_bits(HIDDEN_CNT), idx_bits(n).
  - Weight-index helper functions.
- One natural sub-module: tnn_argmax. It is combinational over CLASS_CNT signed scores, returns the lowest index on ties, and is parametrised by CLASS_CNT and score width.

Test Plan:
- All weights zero, any data, accept at cycle 0: out_valid rises at cycle 60. All scores are -0 (weights 0), so it is a tie and prediction=0.
- W1 zero, W2_POS bits for class 2 all set: all hidden b=1, acc2[2]=40. Expect prediction=2 at cycle 60.
- W1_NEG bit (f=0, h=0) set, feat[0]=15, W2_POS bit (h=0, c=1) set, all other weights zero: acc1[0]=-15 gives b=0 and acc2[1]=-1. Expect prediction=0. Repeat with feat[0]=0: acc1[0]=0 gives b=1, acc2[1]=+1, prediction=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Expect out_valid=1, prediction stable, in_ready=0, and in_valid ignored. After out_ready=1, in_ready=1 on the next cycle.
- Reset at cycle 10 (mid-L1): the following cycle shows in_ready=1 and out_valid=0. A fresh vector accepted then yields the correct prediction 60 cycles later.
- Back-to-back: 3 vectors with in_valid held high and out_ready=1 tied. Accepts are spaced 62 cycles apart, and predictions come out in order, matching a software reference model.
